// File: rtl/control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// control_fsm_pkg
//
// Shared opcode package for the 16-bit core. It holds the instruction
// encodings (Opcode_t, Branch_t), the datapath select enums (ALU function,
// PC source, operand-1 source), the sequencer state enum, and the bit
// positions that split the shared Type C (LDW/STW) and Type E (PUSH/POP)
// opcodes.
//
// Instruction layout:
//   Instr[15:11]  opcode
//   Instr[10:8]   branch condition (Type D)
//   Instr[7]      1 = PUSH, 0 = POP (Type E)
//   Instr[4]      1 = STW,  0 = LDW (Type C)
//
// Helper functions map an ALU opcode to its ALU function and tell whether
// the opcode writes the register file.
// -----------------------------------------------------------------------------
package control_fsm_pkg;

    typedef enum logic [4:0] {
        OP_NOP      = 5'b00000,
        OP_LUI      = 5'b00001,
        OP_LLI      = 5'b00010,
        OP_NEG      = 5'b00011,
        OP_ADD      = 5'b00100,
        OP_ADDI     = 5'b00101,
        OP_ADC      = 5'b00110,
        OP_ADCI     = 5'b00111,
        OP_SUB      = 5'b01000,
        OP_SUBI     = 5'b01001,
        OP_SUC      = 5'b01010,
        OP_SUCI     = 5'b01011,
        OP_NOT      = 5'b01100,
        OP_CMP      = 5'b01101,
        OP_AND      = 5'b01110,
        OP_OR       = 5'b01111,
        OP_XOR      = 5'b10000,
        OP_NAND     = 5'b10001,
        OP_NOR      = 5'b10010,
        OP_LSL      = 5'b10011,
        OP_LSR      = 5'b10100,
        OP_ASR      = 5'b10101,
        OP_LDW_STW  = 5'b10110,
        OP_PUSH_POP = 5'b10111,
        OP_BRANCH   = 5'b11000
    } Opcode_t;

    typedef enum logic [2:0] {
        BR  = 3'd0,
        BWL = 3'd1,
        RET = 3'd2,
        JMP = 3'd3,
        BE  = 3'd4,
        BNE = 3'd5,
        BLT = 3'd6,
        BGE = 3'd7
    } Branch_t;

    typedef enum logic [3:0] {
        FnNOP = 4'd0,
        FnADD = 4'd1,
        FnSUB = 4'd2,
        FnAND = 4'd3,
        FnOR  = 4'd4,
        FnNOT = 4'd5,
        FnLSL = 4'd6,
        FnLSR = 4'd7,
        FnACC = 4'd8
    } alu_functions_t;

    typedef enum logic [1:0] {
        Pc1      = 2'd0,
        PcAluOut = 2'd1,
        PcLr     = 2'd2
    } pc_select_t;

    typedef enum logic [1:0] {
        Op1Pc  = 2'd0,
        Op1Rd1 = 2'd1,
        Op1Sp  = 2'd2
    } Op1_select_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4
    } control_state_t;

    // Select bits that split the shared Type C / Type E opcodes.
    localparam int unsigned TYPE_C_STW_BIT  = 4;
    localparam int unsigned TYPE_E_PUSH_BIT = 7;

    // ALU function for a register-to-register / immediate ALU opcode.
    // Anything that is not an ALU opcode (including unknown encodings)
    // maps to FnNOP, which is how unrecognised opcodes end up as NOPs.
    function automatic alu_functions_t alu_func_for(input Opcode_t op);
        alu_functions_t fn;
        fn = FnNOP;
        case (op)
            OP_ADD, OP_ADDI, OP_ADC, OP_ADCI:                 fn = FnADD;
            OP_SUB, OP_SUBI, OP_SUC, OP_SUCI, OP_NEG, OP_CMP: fn = FnSUB;
            OP_AND:                                           fn = FnAND;
            OP_OR, OP_XOR, OP_NAND, OP_NOR:                   fn = FnOR;
            OP_NOT:                                           fn = FnNOT;
            OP_LSL:                                           fn = FnLSL;
            OP_LSR, OP_ASR:                                   fn = FnLSR;
            OP_LUI, OP_LLI:                                   fn = FnACC;
            default:                                          fn = FnNOP;
        endcase
        return fn;
    endfunction

    // Every ALU opcode writes its result back except CMP (flags only).
    // NOP and unknown encodings have no ALU function and so never write.
    function automatic logic alu_writes_reg(input Opcode_t op);
        return (alu_func_for(op) != FnNOP) && (op != OP_CMP);
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// -----------------------------------------------------------------------------
// control_fsm_if
//
// Bundle between the instruction sequencer and the datapath / bus.
//   Instr      16  instruction register contents (valid from EXEC onward)
//   Z, N        1  flags from the last flag-setting ALU operation
//   MemAck      1  bus transfer complete (wait-state builds only)
//   AluFunc     4  ALU function select
//   PcSel       2  PC source select
//   Op1Sel      2  ALU operand-1 source select
//   PcWe, IrWe, RegWe, SpWe, LrWe   datapath register write enables
//   MemRead, MemWrite               bus strobes
//   AddrSel     1  0 = address from PC, 1 = address from ALU output
//
// master: the sequencer (drives controls, reads instruction/flags/ack).
// slave : the datapath/bus side.
// -----------------------------------------------------------------------------
interface control_fsm_if;
    import control_fsm_pkg::*;

    logic [15:0]    Instr;
    logic           Z;
    logic           N;
    logic           MemAck;

    alu_functions_t AluFunc;
    pc_select_t     PcSel;
    Op1_select_t    Op1Sel;
    logic           PcWe;
    logic           IrWe;
    logic           RegWe;
    logic           SpWe;
    logic           LrWe;
    logic           MemRead;
    logic           MemWrite;
    logic           AddrSel;

    modport master (
        input  Instr, Z, N, MemAck,
        output AluFunc, PcSel, Op1Sel,
        output PcWe, IrWe, RegWe, SpWe, LrWe,
        output MemRead, MemWrite, AddrSel
    );

    modport slave (
        output Instr, Z, N, MemAck,
        input  AluFunc, PcSel, Op1Sel,
        input  PcWe, IrWe, RegWe, SpWe, LrWe,
        input  MemRead, MemWrite, AddrSel
    );

endinterface

// File: rtl/control_fsm_branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
//
// Purely combinational branch-condition evaluator.
//   cond   in  3  Branch_t field of a Type D instruction
//   z      in  1  zero flag
//   n      in  1  negative flag
//   taken  out 1  1 when the branch redirects the PC
//
// BR, BWL, RET and JMP are unconditional.
// -----------------------------------------------------------------------------
module branch_cond
    import control_fsm_pkg::*;
(
    input  Branch_t cond,
    input  logic    z,
    input  logic    n,
    output logic    taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            BR, BWL, RET, JMP: taken = 1'b1;
            BE:                taken = z;
            BNE:               taken = ~z;
            BLT:               taken = n;
            BGE:               taken = ~n;
            default:           taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
//
// Multi-cycle instruction sequencer: IDLE -> FETCH -> EXEC [-> MEM [-> WB]].
// Only the state is registered; every control output is decoded
// combinationally from the state and the instruction register.
//
// Ports
//   Clock   in   system clock, rising edge
//   nReset  in   asynchronous active-low reset
//   bus     control_fsm_if.master (instruction, flags, MemAck, controls)
//
// Latency (no wait states): ALU/branch 2 cycles, LDW/STW/PUSH 3, POP 4.
//
// Build option CONTROL_WAIT_STATE_EN: when defined, FETCH and MEM hold with
// their strobe asserted until MemAck=1, and the write enables of those
// states are gated by MemAck so each fires exactly once. When undefined,
// MemAck is ignored and every bus access completes in one cycle.
// -----------------------------------------------------------------------------
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic          Clock,
    input  logic          nReset,
    control_fsm_if.master bus
);

    control_state_t state_reg;
    control_state_t state_next;

    Opcode_t        opcode;
    Branch_t        branch_code;
    logic           is_store;
    logic           is_push;
    logic           branch_taken;
    logic           bus_done;

    alu_functions_t alu_func;
    pc_select_t     pc_sel;
    Op1_select_t    op1_sel;
    logic           pc_we;
    logic           ir_we;
    logic           reg_we;
    logic           sp_we;
    logic           lr_we;
    logic           mem_read;
    logic           mem_write;
    logic           addr_sel;

    // Instruction fields.
    assign opcode      = Opcode_t'(bus.Instr[15:11]);
    assign branch_code = Branch_t'(bus.Instr[10:8]);
    assign is_store    = bus.Instr[TYPE_C_STW_BIT];
    assign is_push     = bus.Instr[TYPE_E_PUSH_BIT];

    // Operand/immediate bits are consumed by the datapath, not here.
    logic [5:0] unused_instr_bits;
    assign unused_instr_bits = {bus.Instr[6:5], bus.Instr[3:0]};

`ifdef CONTROL_WAIT_STATE_EN
    assign bus_done = bus.MemAck;
`else
    logic unused_mem_ack;
    assign unused_mem_ack = bus.MemAck;
    assign bus_done       = 1'b1;
`endif

    branch_cond u_branch_cond (
        .cond  (branch_code),
        .z     (bus.Z),
        .n     (bus.N),
        .taken (branch_taken)
    );

    // State register. The asynchronous reset drops straight to IDLE, whose
    // outputs are all inactive, so an abandoned instruction writes nothing.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next = state_reg;
        alu_func   = FnNOP;
        pc_sel     = Pc1;
        op1_sel    = Op1Pc;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        sp_we      = 1'b0;
        lr_we      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr_sel   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                // Read at PC, latch IR and advance PC once the bus completes.
                mem_read = 1'b1;
                addr_sel = 1'b0;
                pc_sel   = Pc1;
                ir_we    = bus_done;
                pc_we    = bus_done;
                if (bus_done) begin
                    state_next = EXEC;
                end
            end

            EXEC: begin
                state_next = FETCH;
                case (opcode)
                    OP_LDW_STW: begin
                        // Effective address Ra + offset.
                        alu_func   = FnADD;
                        op1_sel    = Op1Rd1;
                        state_next = MEM;
                    end

                    OP_PUSH_POP: begin
                        // PUSH pre-decrements SP; POP does its writes later.
                        if (is_push) begin
                            alu_func = FnSUB;
                            op1_sel  = Op1Sp;
                            sp_we    = 1'b1;
                        end
                        state_next = MEM;
                    end

                    OP_BRANCH: begin
                        // Default is PC-relative (PC + offset); the
                        // condition only gates the PC write.
                        alu_func = FnADD;
                        op1_sel  = Op1Pc;
                        pc_sel   = PcAluOut;
                        pc_we    = branch_taken;
                        case (branch_code)
                            BWL: lr_we = 1'b1;
                            RET: begin
                                alu_func = FnNOP;
                                pc_sel   = PcLr;
                            end
                            JMP: op1_sel = Op1Rd1;
                            default: ;
                        endcase
                    end

                    default: begin
                        // ALU ops; NOP and unknown opcodes decode to
                        // FnNOP with no register write.
                        alu_func = alu_func_for(opcode);
                        if (alu_func != FnNOP) begin
                            op1_sel = Op1Rd1;
                        end
                        reg_we = alu_writes_reg(opcode);
                    end
                endcase
            end

            MEM: begin
                addr_sel = 1'b1;
                if (bus_done) begin
                    state_next = FETCH;
                end
                if ((opcode == OP_LDW_STW && is_store) ||
                    (opcode == OP_PUSH_POP && is_push)) begin
                    mem_write = 1'b1;
                end else if (opcode == OP_PUSH_POP) begin
                    // POP: load from the current SP, increment it in WB.
                    mem_read = 1'b1;
                    reg_we   = bus_done;
                    op1_sel  = Op1Sp;
                    if (bus_done) begin
                        state_next = WB;
                    end
                end else if (opcode == OP_LDW_STW) begin
                    mem_read = 1'b1;
                    reg_we   = bus_done;
                end else begin
                    // MEM is only entered for Type C/E; anything else is
                    // abandoned without a bus access.
                    addr_sel   = 1'b0;
                    state_next = FETCH;
                end
            end

            WB: begin
                alu_func   = FnADD;
                op1_sel    = Op1Sp;
                sp_we      = 1'b1;
                state_next = FETCH;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.AluFunc  = alu_func;
    assign bus.PcSel    = pc_sel;
    assign bus.Op1Sel   = op1_sel;
    assign bus.PcWe     = pc_we;
    assign bus.IrWe     = ir_we;
    assign bus.RegWe    = reg_we;
    assign bus.SpWe     = sp_we;
    assign bus.LrWe     = lr_we;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.AddrSel  = addr_sel;

endmodule

// File: tb/tb_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_fsm
//
// Directed testbench for control_fsm. Inputs are driven 2 time units after
// the rising edge and outputs sampled 1 unit later. The enable vector
// compared in most checks is packed as
//   {PcWe, IrWe, RegWe, SpWe, LrWe, MemRead, MemWrite, AddrSel}
// Build with +define+CONTROL_WAIT_STATE_EN to cover the MemAck handshake.
// -----------------------------------------------------------------------------
module tb_control_fsm;
    import control_fsm_pkg::*;

    logic clk = 1'b0;
    logic n_reset;
    int   checks = 0;
    int   errors = 0;

    control_fsm_if bus ();

    control_fsm dut (
        .Clock  (clk),
        .nReset (n_reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Hand-encoded instructions: {opcode[4:0], rest[10:0]}.
    localparam logic [15:0] I_ADD  = {5'b00100, 11'h123};
    localparam logic [15:0] I_CMP  = {5'b01101, 11'h045};
    localparam logic [15:0] I_BNE  = {5'b11000, 3'd5, 8'h12};
    localparam logic [15:0] I_BWL  = {5'b11000, 3'd1, 8'h34};
    localparam logic [15:0] I_RET  = {5'b11000, 3'd2, 8'h00};
    localparam logic [15:0] I_BLT  = {5'b11000, 3'd6, 8'h07};
    localparam logic [15:0] I_BGE  = {5'b11000, 3'd7, 8'h07};
    localparam logic [15:0] I_LDW  = {5'b10110, 11'b000_0000_0010};
    localparam logic [15:0] I_STW  = {5'b10110, 11'b000_0001_0010};
    localparam logic [15:0] I_PUSH = {5'b10111, 11'b000_1000_0000};
    localparam logic [15:0] I_POP  = {5'b10111, 11'b000_0000_0000};
    localparam logic [15:0] I_BAD  = {5'b11111, 11'h7FF};

    // Expected enable vectors.
    localparam logic [15:0] EN_NONE   = 16'h0000;
    localparam logic [15:0] EN_FETCH  = 16'h00C4; // PcWe IrWe MemRead
    localparam logic [15:0] EN_FWAIT  = 16'h0004; // MemRead only
    localparam logic [15:0] EN_REG    = 16'h0020; // RegWe
    localparam logic [15:0] EN_PC     = 16'h0080; // PcWe
    localparam logic [15:0] EN_PC_LR  = 16'h0088; // PcWe LrWe
    localparam logic [15:0] EN_SP     = 16'h0010; // SpWe
    localparam logic [15:0] EN_LOAD   = 16'h0025; // RegWe MemRead AddrSel
    localparam logic [15:0] EN_LWAIT  = 16'h0005; // MemRead AddrSel
    localparam logic [15:0] EN_STORE  = 16'h0003; // MemWrite AddrSel

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [15:0] en_word();
        return {8'd0, bus.PcWe, bus.IrWe, bus.RegWe, bus.SpWe, bus.LrWe,
                bus.MemRead, bus.MemWrite, bus.AddrSel};
    endfunction

    function automatic logic [15:0] ctl_word();
        return {bus.AluFunc, bus.PcSel, bus.Op1Sel, bus.PcWe, bus.IrWe, bus.RegWe,
                bus.SpWe, bus.LrWe, bus.MemRead, bus.MemWrite, bus.AddrSel};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Advance into FETCH, load the next instruction and check the fetch cycle.
    task automatic fetch_with(input string tag, input logic [15:0] instr);
        tick();
        bus.Instr = instr;
        settle();
        check_eq({tag, "_fetch_en"}, en_word(), EN_FETCH);
    endtask

    task automatic exec_cycle();
        tick();
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset    = 1'b0;
        bus.Instr  = 16'h0000;
        bus.Z      = 1'b0;
        bus.N      = 1'b0;
        bus.MemAck = 1'b1;

        // Reset and release.
        repeat (2) @(posedge clk);
        #2;
        settle();
        check_eq("reset_outputs", ctl_word(), 16'h0000);
        n_reset = 1'b1;
        settle();
        check_eq("idle_after_release", ctl_word(), 16'h0000);

        // ADD: FETCH, EXEC (FnADD, RegWe), then FETCH again.
        fetch_with("add", I_ADD);
        check_eq("add_fetch_pcsel", 16'(bus.PcSel), 16'(Pc1));
        exec_cycle();
        check_eq("add_exec_en", en_word(), EN_REG);
        check_eq("add_exec_alu", 16'(bus.AluFunc), 16'(FnADD));
        check_eq("add_exec_op1", 16'(bus.Op1Sel), 16'(Op1Rd1));

        // CMP: FnSUB, no register write.
        fetch_with("cmp", I_CMP);
        exec_cycle();
        check_eq("cmp_exec_en", en_word(), EN_NONE);
        check_eq("cmp_exec_alu", 16'(bus.AluFunc), 16'(FnSUB));

        // BNE with Z=1: not taken.
        bus.Z = 1'b1;
        fetch_with("bne_z1", I_BNE);
        exec_cycle();
        check_eq("bne_z1_en", en_word(), EN_NONE);

        // BNE with Z=0: taken via ALU output.
        bus.Z = 1'b0;
        fetch_with("bne_z0", I_BNE);
        exec_cycle();
        check_eq("bne_z0_en", en_word(), EN_PC);
        check_eq("bne_z0_pcsel", 16'(bus.PcSel), 16'(PcAluOut));

        // BWL: PC and LR written together, PC-relative.
        fetch_with("bwl", I_BWL);
        exec_cycle();
        check_eq("bwl_en", en_word(), EN_PC_LR);
        check_eq("bwl_alu", 16'(bus.AluFunc), 16'(FnADD));
        check_eq("bwl_op1", 16'(bus.Op1Sel), 16'(Op1Pc));

        // RET: PC from LR.
        fetch_with("ret", I_RET);
        exec_cycle();
        check_eq("ret_en", en_word(), EN_PC);
        check_eq("ret_pcsel", 16'(bus.PcSel), 16'(PcLr));

        // BLT with N=1 taken, BGE with N=1 not taken.
        bus.N = 1'b1;
        fetch_with("blt_n1", I_BLT);
        exec_cycle();
        check_eq("blt_n1_en", en_word(), EN_PC);
        fetch_with("bge_n1", I_BGE);
        exec_cycle();
        check_eq("bge_n1_en", en_word(), EN_NONE);
        bus.N = 1'b0;

        // Unrecognised opcode behaves as NOP (2-cycle, no writes).
        fetch_with("bad", I_BAD);
        exec_cycle();
        check_eq("bad_exec_en", en_word(), EN_NONE);

        // LDW: EXEC (FnADD, no writes), MEM (read, RegWe), then FETCH.
        fetch_with("ldw", I_LDW);
        exec_cycle();
        check_eq("ldw_exec_en", en_word(), EN_NONE);
        check_eq("ldw_exec_alu", 16'(bus.AluFunc), 16'(FnADD));
        exec_cycle();
        check_eq("ldw_mem_en", en_word(), EN_LOAD);

        // STW: MEM writes.
        fetch_with("stw", I_STW);
        exec_cycle();
        check_eq("stw_exec_en", en_word(), EN_NONE);
        exec_cycle();
        check_eq("stw_mem_en", en_word(), EN_STORE);

        // PUSH: EXEC decrements SP, MEM writes.
        fetch_with("push", I_PUSH);
        exec_cycle();
        check_eq("push_exec_en", en_word(), EN_SP);
        check_eq("push_exec_alu", 16'(bus.AluFunc), 16'(FnSUB));
        check_eq("push_exec_op1", 16'(bus.Op1Sel), 16'(Op1Sp));
        exec_cycle();
        check_eq("push_mem_en", en_word(), EN_STORE);

        // POP: EXEC (nothing) -> MEM (read, RegWe) -> WB (SpWe, FnADD) -> FETCH.
        fetch_with("pop", I_POP);
        exec_cycle();
        check_eq("pop_exec_en", en_word(), EN_NONE);
        exec_cycle();
        check_eq("pop_mem_en", en_word(), EN_LOAD);
        check_eq("pop_mem_op1", 16'(bus.Op1Sel), 16'(Op1Sp));
        exec_cycle();
        check_eq("pop_wb_en", en_word(), EN_SP);
        check_eq("pop_wb_alu", 16'(bus.AluFunc), 16'(FnADD));
        check_eq("pop_wb_op1", 16'(bus.Op1Sel), 16'(Op1Sp));

        // Reset pulsed in the MEM cycle of an LDW: outputs drop at once.
        fetch_with("ldw_rst", I_LDW);
        exec_cycle();
        exec_cycle();
        check_eq("ldw_rst_mem_en", en_word(), EN_LOAD);
        n_reset = 1'b0;
        settle();
        check_eq("ldw_rst_asserted", ctl_word(), 16'h0000);
        tick();
        settle();
        check_eq("ldw_rst_held", ctl_word(), 16'h0000);
        n_reset = 1'b1;
        settle();
        check_eq("ldw_rst_idle", ctl_word(), 16'h0000);
        bus.Instr = I_ADD;
        tick();
        settle();
        check_eq("ldw_rst_fetch_en", en_word(), EN_FETCH);
        exec_cycle();
        check_eq("ldw_rst_next_exec_en", en_word(), EN_REG);

`ifdef CONTROL_WAIT_STATE_EN
        // FETCH held while MemAck=0: strobe high, no IR/PC writes.
        tick();
        bus.MemAck = 1'b0;
        bus.Instr  = I_STW;
        settle();
        check_eq("ws_fetch_wait1", en_word(), EN_FWAIT);
        tick();
        settle();
        check_eq("ws_fetch_wait2", en_word(), EN_FWAIT);
        bus.MemAck = 1'b1;
        settle();
        check_eq("ws_fetch_ack", en_word(), EN_FETCH);
        exec_cycle();
        check_eq("ws_stw_exec_en", en_word(), EN_NONE);
        // STW MEM with MemAck low for 3 cycles, high on the 4th.
        tick();
        bus.MemAck = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("ws_stw_mem_wait%0d", i), en_word(), EN_STORE);
            tick();
            settle();
        end
        bus.MemAck = 1'b1;
        settle();
        check_eq("ws_stw_mem_ack", en_word(), EN_STORE);
        bus.Instr = I_LDW;
        exec_cycle();
        check_eq("ws_stw_then_fetch", en_word(), EN_FETCH);
        // LDW MEM: RegWe only in the acknowledged cycle.
        exec_cycle();
        tick();
        bus.MemAck = 1'b0;
        settle();
        check_eq("ws_ldw_mem_wait", en_word(), EN_LWAIT);
        bus.MemAck = 1'b1;
        settle();
        check_eq("ws_ldw_mem_ack", en_word(), EN_LOAD);
        exec_cycle();
        check_eq("ws_ldw_then_fetch", en_word(), EN_FETCH);
`else
        // MemAck is ignored: FETCH completes in one cycle even with it low.
        bus.MemAck = 1'b0;
        fetch_with("noack", I_ADD);
        exec_cycle();
        check_eq("noack_exec_en", en_word(), EN_REG);
        fetch_with("noack_ldw", I_LDW);
        exec_cycle();
        exec_cycle();
        check_eq("noack_ldw_mem_en", en_word(), EN_LOAD);
        exec_cycle();
        check_eq("noack_ldw_then_fetch", en_word(), EN_FETCH);
        bus.MemAck = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
